// File: rtl/swipt_data_link.sv
// swipt_data_link
//   Transmitter-side serial data link for the SWIPT power stage. It runs only
//   when the power link is alive and the top-level phase is 2'b11. Each round
//   requests a mean-current baseline and sends an 8-bit preamble plus nine
//   16-bit telemetry words on dout, MSB first. It then decodes the receiver's
//   load-modulated reply from ADC samples against that baseline and publishes
//   the received efficiency, the received power and a duty up/down request.
//
//   Optional build macro: DATA_LINK_PARITY_EN
//     When defined, the reply carries an 18th bit holding even parity over
//     the 17 payload bits. A mismatch discards the reply.
//
// Ports
//   clk               in   system clock, rising edge
//   nrst              in   asynchronous active-low reset
//   swiptAlive        in   power link alive; low forces IDLE
//   program_phase     in   [1:0] top-level phase; block runs only at 2'b11
//   ADC               in   [11:0] unsigned coil-current sample
//   meanCurrent       in   [11:0] averaged current (baseline source)
//   SWIPT_P_TX .. COMMS_FLIGHT_TIME  in [15:0] telemetry, sent in port order
//   RECEIVED_EFF      out  [7:0] last valid efficiency byte
//   RECEIVED_POWER_RX out  [7:0] last valid received-power byte
//   read              out  high while listening for the reply
//   write             out  high while transmitting
//   dout              out  serial transmit bit
//   l_rdy             out  one-cycle strobe, l_up_down valid
//   l_up_down         out  0 = increase duty, 1 = decrease duty
//   getMeanCurrent    out  request to accumulate mean current
module swipt_data_link #(
   parameter int         BIT_CYCLES  = 100,
   parameter int         MEAS_CYCLES = 1000,
   parameter int         RX_TIMEOUT  = 10000,
   parameter int         THRESH      = 64,
   parameter logic [7:0] PREAMBLE    = 8'hA5
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        swiptAlive,
   input  logic [1:0]  program_phase,
   input  logic [11:0] ADC,
   input  logic [11:0] meanCurrent,
   input  logic [15:0] SWIPT_P_TX,
   input  logic [15:0] SWIPT_DUTY,
   input  logic [15:0] SWIPT_FREQ,
   input  logic [15:0] SWIPT_ASCII,
   input  logic [15:0] ANC_MAX_HEIGHT,
   input  logic [15:0] ANC_MIN_HEIGHT,
   input  logic [15:0] COMMS_TRAJECT,
   input  logic [15:0] COMMS_QR_CODES,
   input  logic [15:0] COMMS_FLIGHT_TIME,
   output logic [7:0]  RECEIVED_EFF,
   output logic [7:0]  RECEIVED_POWER_RX,
   output logic        read,
   output logic        write,
   output logic        dout,
   output logic        l_rdy,
   output logic        l_up_down,
   output logic        getMeanCurrent
);

`ifdef DATA_LINK_PARITY_EN
   localparam int RX_BITS_N = 18;
`else
   localparam int RX_BITS_N = 17;
`endif
   localparam int CNT_MAX = (MEAS_CYCLES > BIT_CYCLES) ? MEAS_CYCLES : BIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TO_W    = $clog2(RX_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_MEAS, S_TX, S_RX_WAIT, S_RX_START, S_RX_BITS, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TO_W-1:0]      to_q, to_d;
   logic [4:0]           bit_q, bit_d;
   logic [3:0]           word_q, word_d;
   logic [15:0]          tx_sh_q, tx_sh_d;
   logic [RX_BITS_N-2:0] rx_sh_q, rx_sh_d;
   logic [11:0]          baseline_q, baseline_d;
   logic                 write_q, write_d;
   logic                 read_q, read_d;
   logic                 gmc_q, gmc_d;
   logic                 l_rdy_q, l_rdy_d;
   logic                 l_ud_q, l_ud_d;
   logic [7:0]           eff_q, eff_d;
   logic [7:0]           pwr_q, pwr_d;

   logic                 run;
   logic                 adc_hi;
   logic                 parity_ok;
   logic [RX_BITS_N-1:0] rx_full;
   logic [15:0]          next_word;

   assign run     = swiptAlive && (program_phase == 2'b11);
   // 13-bit compare so a baseline near full scale cannot wrap the threshold.
   assign adc_hi  = {1'b0, ADC} > ({1'b0, baseline_q} + 13'(THRESH));
   assign rx_full = {rx_sh_q, adc_hi};

`ifdef DATA_LINK_PARITY_EN
   assign parity_ok = ~^rx_full;
`else
   assign parity_ok = 1'b1;
`endif

   // word_q holds the index of the word being sent (0 = preamble), so the
   // word that follows it is telemetry input word_q.
   always_comb begin
      next_word = 16'h0000;
      case (word_q)
         4'd0:    next_word = SWIPT_P_TX;
         4'd1:    next_word = SWIPT_DUTY;
         4'd2:    next_word = SWIPT_FREQ;
         4'd3:    next_word = SWIPT_ASCII;
         4'd4:    next_word = ANC_MAX_HEIGHT;
         4'd5:    next_word = ANC_MIN_HEIGHT;
         4'd6:    next_word = COMMS_TRAJECT;
         4'd7:    next_word = COMMS_QR_CODES;
         4'd8:    next_word = COMMS_FLIGHT_TIME;
         default: next_word = 16'h0000;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      to_d       = to_q;
      bit_d      = bit_q;
      word_d     = word_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      baseline_d = baseline_q;
      write_d    = write_q;
      read_d     = read_q;
      gmc_d      = gmc_q;
      l_rdy_d    = 1'b0;
      l_ud_d     = l_ud_q;
      eff_d      = eff_q;
      pwr_d      = pwr_q;

      if (!run) begin
         // Abort beats everything else, including a reply completing now.
         state_d = S_IDLE;
         cnt_d   = '0;
         to_d    = '0;
         bit_d   = '0;
         word_d  = '0;
         tx_sh_d = '0;
         rx_sh_d = '0;
         write_d = 1'b0;
         read_d  = 1'b0;
         gmc_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_MEAS;
               gmc_d   = 1'b1;
               cnt_d   = '0;
            end

            S_MEAS: begin
               if (cnt_q == CNT_W'(MEAS_CYCLES - 1)) begin
                  gmc_d = 1'b0;
                  cnt_d = cnt_q + 1'b1;
               end else if (cnt_q == CNT_W'(MEAS_CYCLES)) begin
                  // Request dropped for one cycle; the averager result is final.
                  baseline_d = meanCurrent;
                  state_d    = S_TX;
                  write_d    = 1'b1;
                  tx_sh_d    = {PREAMBLE, 8'h00};
                  cnt_d      = '0;
                  bit_d      = '0;
                  word_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_TX: begin
               if (cnt_q == CNT_W'(BIT_CYCLES - 1)) begin
                  cnt_d = '0;
                  if (bit_q == ((word_q == 4'd0) ? 5'd7 : 5'd15)) begin
                     bit_d = '0;
                     if (word_q == 4'd9) begin
                        state_d = S_RX_WAIT;
                        write_d = 1'b0;
                        read_d  = 1'b1;
                        tx_sh_d = '0;
                        to_d    = '0;
                        word_d  = '0;
                     end else begin
                        // Telemetry is captured here, so later changes to
                        // the input cannot disturb the word in flight.
                        word_d  = word_q + 1'b1;
                        tx_sh_d = next_word;
                     end
                  end else begin
                     bit_d   = bit_q + 1'b1;
                     tx_sh_d = {tx_sh_q[14:0], 1'b0};
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_RX_WAIT: begin
               if (adc_hi) begin
                  state_d = S_RX_START;
                  cnt_d   = CNT_W'(1);
               end else if (to_q == TO_W'(RX_TIMEOUT - 1)) begin
                  state_d = S_MEAS;
                  read_d  = 1'b0;
                  gmc_d   = 1'b1;
                  cnt_d   = '0;
                  to_d    = '0;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end

            S_RX_START: begin
               // Re-check the start bit at its centre to reject glitches.
               if (cnt_q == CNT_W'(BIT_CYCLES / 2)) begin
                  if (adc_hi) begin
                     state_d = S_RX_BITS;
                     cnt_d   = CNT_W'(1);
                     bit_d   = '0;
                     rx_sh_d = '0;
                  end else begin
                     state_d = S_RX_WAIT;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_RX_BITS: begin
               if (cnt_q == CNT_W'(BIT_CYCLES)) begin
                  cnt_d = CNT_W'(1);
                  if (bit_q == 5'(RX_BITS_N - 1)) begin
                     read_d  = 1'b0;
                     bit_d   = '0;
                     rx_sh_d = '0;
                     cnt_d   = '0;
                     if (parity_ok) begin
                        state_d = S_DONE;
                        eff_d   = rx_full[RX_BITS_N-1 -: 8];
                        pwr_d   = rx_full[RX_BITS_N-9 -: 8];
                        l_ud_d  = rx_full[RX_BITS_N-17];
                        l_rdy_d = 1'b1;
                     end else begin
                        state_d = S_MEAS;
                        gmc_d   = 1'b1;
                     end
                  end else begin
                     bit_d   = bit_q + 1'b1;
                     rx_sh_d = rx_full[RX_BITS_N-2:0];
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_DONE: begin
               state_d = S_MEAS;
               gmc_d   = 1'b1;
               cnt_d   = '0;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         to_q       <= '0;
         bit_q      <= '0;
         word_q     <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         baseline_q <= '0;
         write_q    <= 1'b0;
         read_q     <= 1'b0;
         gmc_q      <= 1'b0;
         l_rdy_q    <= 1'b0;
         l_ud_q     <= 1'b0;
         eff_q      <= '0;
         pwr_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         to_q       <= to_d;
         bit_q      <= bit_d;
         word_q     <= word_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         baseline_q <= baseline_d;
         write_q    <= write_d;
         read_q     <= read_d;
         gmc_q      <= gmc_d;
         l_rdy_q    <= l_rdy_d;
         l_ud_q     <= l_ud_d;
         eff_q      <= eff_d;
         pwr_q      <= pwr_d;
      end
   end

   // The shift register is cleared outside TX, so its MSB is the line level.
   assign dout              = tx_sh_q[15];
   assign write             = write_q;
   assign read              = read_q;
   assign getMeanCurrent    = gmc_q;
   assign l_rdy             = l_rdy_q;
   assign l_up_down         = l_ud_q;
   assign RECEIVED_EFF      = eff_q;
   assign RECEIVED_POWER_RX = pwr_q;

endmodule

// File: tb/tb_swipt_data_link.sv
module tb_swipt_data_link;
   localparam int BC    = 100;
   localparam int MEAS  = 1000;
   localparam int TOUT  = 10000;
   localparam int NWORD = 9;

   logic        clk = 1'b0;
   logic        nrst;
   logic        swiptAlive;
   logic [1:0]  program_phase;
   logic [11:0] ADC;
   logic [11:0] meanCurrent;
   logic [15:0] tel [NWORD];
   logic [7:0]  RECEIVED_EFF;
   logic [7:0]  RECEIVED_POWER_RX;
   logic        read, write, dout, l_rdy, l_up_down, getMeanCurrent;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0] eff;
      logic [7:0] pwr;
      logic       ud;
   } reply_t;

   reply_t rep_q [$];
   logic   exp_bits [$];
   reply_t last_rep = '0;

   always #5 clk = ~clk;

   swipt_data_link dut (
      .clk               (clk),
      .nrst              (nrst),
      .swiptAlive        (swiptAlive),
      .program_phase     (program_phase),
      .ADC               (ADC),
      .meanCurrent       (meanCurrent),
      .SWIPT_P_TX        (tel[0]),
      .SWIPT_DUTY        (tel[1]),
      .SWIPT_FREQ        (tel[2]),
      .SWIPT_ASCII       (tel[3]),
      .ANC_MAX_HEIGHT    (tel[4]),
      .ANC_MIN_HEIGHT    (tel[5]),
      .COMMS_TRAJECT     (tel[6]),
      .COMMS_QR_CODES    (tel[7]),
      .COMMS_FLIGHT_TIME (tel[8]),
      .RECEIVED_EFF      (RECEIVED_EFF),
      .RECEIVED_POWER_RX (RECEIVED_POWER_RX),
      .read              (read),
      .write             (write),
      .dout              (dout),
      .l_rdy             (l_rdy),
      .l_up_down         (l_up_down),
      .getMeanCurrent    (getMeanCurrent)
   );

   function automatic logic [21:0] outs();
      return {RECEIVED_EFF, RECEIVED_POWER_RX, read, write, dout, l_rdy,
              l_up_down, getMeanCurrent};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic count_meas(input string name);
      int n;
      for (int i = 0; i < 10 && getMeanCurrent !== 1'b1; i++) tick();
      n = 0;
      while (getMeanCurrent === 1'b1 && n < 3000) begin
         n++;
         tick();
      end
      total++;
      if (n != MEAS) begin
         bad++;
         $display("FAIL %s: getMeanCurrent high %0d cycles, required %0d", name, n, MEAS);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0; swiptAlive = 1'b0; program_phase = 2'b00;
      repeat (3) tick();
      total++;
      if (outs() !== 22'h0) begin
         bad++;
         $display("FAIL reset_outputs: got=%h required=0", outs());
      end
      program_phase = 2'b11; swiptAlive = 1'b1; nrst = 1'b1;
      count_meas("meas_after_reset");
      for (int i = 0; i < 10 && write !== 1'b1; i++) tick();
      repeat (40 * BC) tick();
      total++;
      if (write !== 1'b1) begin
         bad++;
         $display("FAIL tx_active_bit40: write=%b required=1", write);
      end
      #2 nrst = 1'b0;
      #1;
      total++;
      if (outs() !== 22'h0) begin
         bad++;
         $display("FAIL reset_mid_tx: got=%h required=0", outs());
      end
      tick();
      nrst = 1'b1;
      count_meas("meas_after_mid_tx_reset");
   endtask

   task automatic test_tx_frame(input string name);
      logic [15:0] expw [NWORD];
      logic [7:0]  pre;
      logic        e;
      int          wc, errs, w;
      pre = 8'hA5;
      for (int i = 0; i < NWORD; i++) expw[i] = tel[i];
      exp_bits.delete();
      for (int b = 7; b >= 0; b--) exp_bits.push_back(pre[b]);
      for (int i = 0; i < NWORD; i++)
         for (int b = 15; b >= 0; b--) exp_bits.push_back(expw[i][b]);
      for (int i = 0; i < 2000 && write !== 1'b1; i++) tick();
      total++;
      if (write !== 1'b1) begin
         bad++;
         $display("FAIL %s_start: write=%b required=1", name, write);
         return;
      end
      wc = 0;
      for (int b = 0; b < 152; b++) begin
         e = exp_bits.pop_front();
         errs = 0;
         for (int c = 0; c < BC; c++) begin
            if (write === 1'b1) wc++;
            if (dout !== e || write !== 1'b1) errs++;
            // The word in flight was captured at its MSB; disturb its input.
            if (c == 1 && b >= 8 && ((b - 8) % 16) == 0) begin
               w = (b - 8) / 16;
               tel[w] = ~expw[w];
            end
            tick();
         end
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL %s_bit%0d: %0d cycles differ, required dout=%b write=1", name, b, errs, e);
         end
      end
      total++;
      if (wc != 152 * BC) begin
         bad++;
         $display("FAIL %s_write_len: got=%0d required=%0d", name, wc, 152 * BC);
      end
      total++;
      if ({write, dout, read} !== 3'b001) begin
         bad++;
         $display("FAIL %s_end: write,dout,read=%b required=001", name, {write, dout, read});
      end
      for (int i = 0; i < NWORD; i++) tel[i] = expw[i];
   endtask

   task automatic test_reply(input logic [7:0] eff, input logic [7:0] pwr,
                             input logic ud, input logic good);
      logic [16:0] payload;
      logic [17:0] bits;
      int          nb;
      reply_t      exp;
      logic        upd;
      payload = {eff, pwr, ud};
`ifdef DATA_LINK_PARITY_EN
      nb   = 18;
      bits = {payload, (^payload) ^ ~good};
      upd  = good;
`else
      nb   = 17;
      bits = {1'b0, payload};
      upd  = 1'b1;
`endif
      if (upd) rep_q.push_back(reply_t'({eff, pwr, ud}));
      fork
         begin
            ADC = 12'd500;
            repeat (20) tick();
            ADC = 12'd700;
            repeat (BC) tick();
            for (int k = nb - 1; k >= 0; k--) begin
               ADC = bits[k] ? 12'd700 : 12'd500;
               repeat (BC) tick();
            end
            ADC = 12'd500;
         end
         begin
            logic got;
            int   seen;
            if (upd) begin
               got = 1'b0;
               for (int i = 0; i < 3000 && !got; i++) begin
                  if (l_rdy === 1'b1) got = 1'b1;
                  else tick();
               end
               total++;
               if (!got) begin
                  bad++;
                  $display("FAIL reply_strobe: no l_rdy within 3000 cycles");
               end else begin
                  exp = rep_q.pop_front();
                  total++;
                  if (RECEIVED_EFF !== exp.eff) begin
                     bad++;
                     $display("FAIL reply_eff: got=%h required=%h", RECEIVED_EFF, exp.eff);
                  end
                  total++;
                  if (RECEIVED_POWER_RX !== exp.pwr) begin
                     bad++;
                     $display("FAIL reply_pwr: got=%h required=%h", RECEIVED_POWER_RX, exp.pwr);
                  end
                  total++;
                  if ({l_up_down, read} !== {exp.ud, 1'b0}) begin
                     bad++;
                     $display("FAIL reply_ud_read: got=%b required=%b", {l_up_down, read}, {exp.ud, 1'b0});
                  end
                  last_rep = exp;
                  tick();
                  total++;
                  if ({l_rdy, getMeanCurrent} !== 2'b01) begin
                     bad++;
                     $display("FAIL reply_after: l_rdy,gmc=%b required=01", {l_rdy, getMeanCurrent});
                  end
               end
            end else begin
               seen = 0;
               for (int i = 0; i < 3000 && getMeanCurrent !== 1'b1; i++) begin
                  if (l_rdy === 1'b1) seen++;
                  tick();
               end
               total++;
               if (seen != 0 || getMeanCurrent !== 1'b1) begin
                  bad++;
                  $display("FAIL parity_reject: l_rdy seen %0d, gmc=%b required 0 and 1", seen, getMeanCurrent);
               end
               total++;
               if ({RECEIVED_EFF, RECEIVED_POWER_RX, l_up_down} !== last_rep) begin
                  bad++;
                  $display("FAIL parity_hold: got=%h required=%h",
                           {RECEIVED_EFF, RECEIVED_POWER_RX, l_up_down}, last_rep);
               end
            end
         end
      join
   endtask

   task automatic test_timeout();
      int n, seen;
      ADC = 12'd560;
      n = 0; seen = 0;
      while (read === 1'b1 && n < 12000) begin
         if (l_rdy === 1'b1) seen++;
         n++;
         tick();
      end
      total++;
      if (n != TOUT) begin
         bad++;
         $display("FAIL timeout_len: read high %0d cycles, required %0d", n, TOUT);
      end
      total++;
      if ({read, getMeanCurrent, seen != 0} !== 3'b010) begin
         bad++;
         $display("FAIL timeout_to_meas: read,gmc,rdy_seen=%b required=010", {read, getMeanCurrent, seen != 0});
      end
      total++;
      if ({RECEIVED_EFF, RECEIVED_POWER_RX, l_up_down} !== last_rep) begin
         bad++;
         $display("FAIL timeout_hold: got=%h required=%h", {RECEIVED_EFF, RECEIVED_POWER_RX, l_up_down}, last_rep);
      end
      ADC = 12'd500;
   endtask

   task automatic test_abort();
      logic [16:0] bits;
      int seen;
      bits = {8'h11, 8'h22, 1'b0};
      ADC = 12'd500;
      repeat (20) tick();
      ADC = 12'd700;
      repeat (BC) tick();
      for (int k = 16; k >= 12; k--) begin
         ADC = bits[k] ? 12'd700 : 12'd500;
         repeat (BC) tick();
      end
      swiptAlive = 1'b0;
      tick();
      total++;
      if ({read, write, getMeanCurrent, l_rdy} !== 4'b0000) begin
         bad++;
         $display("FAIL abort_ctrl: read,write,gmc,l_rdy=%b required=0000", {read, write, getMeanCurrent, l_rdy});
      end
      seen = 0;
      for (int i = 0; i < 2000; i++) begin
         if (l_rdy === 1'b1) seen++;
         tick();
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL abort_no_rdy: l_rdy seen %0d cycles, required 0", seen);
      end
      total++;
      if ({RECEIVED_EFF, RECEIVED_POWER_RX, l_up_down} !== last_rep) begin
         bad++;
         $display("FAIL abort_hold: got=%h required=%h", {RECEIVED_EFF, RECEIVED_POWER_RX, l_up_down}, last_rep);
      end
      ADC = 12'd500;
      swiptAlive = 1'b1;
      tick();
      total++;
      if (getMeanCurrent !== 1'b1) begin
         bad++;
         $display("FAIL abort_restart: gmc=%b required=1", getMeanCurrent);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b0; swiptAlive = 1'b0; program_phase = 2'b00;
      ADC = 12'd500; meanCurrent = 12'd500;
      for (int i = 0; i < NWORD; i++) tel[i] = 16'h9999;

      test_reset();
      test_tx_frame("frame_9999");
      test_reply(8'h5A, 8'hC3, 1'b1, 1'b1);

      for (int i = 0; i < NWORD; i++) tel[i] = 16'hC3A0 + 16'(i * 257);
      test_tx_frame("frame_mixed");
      test_timeout();

      for (int i = 0; i < NWORD; i++) tel[i] = 16'h0F1E ^ 16'(i * 4369);
      test_tx_frame("frame_alt");
      test_abort();

`ifdef DATA_LINK_PARITY_EN
      test_tx_frame("frame_parity");
      test_reply(8'h3C, 8'h81, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/swipt_data_link.md
Name: swipt_data_link

Overview:
- Transmitter-side serial data link for the SWIPT power stage. Active only in the data/power-optimisation phase (program = 2'b11).
- Each round trip:
  - requests a mean-current baseline;
  - serialises nine 16-bit telemetry words on dout, which DutyAdjust turns into duty modulation;
  - decodes the receiver's load-modulated reply from the ADC current samples;
  - publishes the received efficiency, received power and a duty up/down request.

Parameters:
- BIT_CYCLES, 100, clock cycles per transmitted or received bit (≥4, even).
- MEAS_CYCLES, 1000, cycles getMeanCurrent is held high before the baseline is latched.
- RX_TIMEOUT, 10000, cycles to wait for the receiver start bit before the round is abandoned.
- THRESH, 64, 12-bit margin above the baseline that decodes a received '1'.
- PREAMBLE, 8'hA5, sync byte sent before the telemetry words.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- swiptAlive  in  1  power link alive; low forces IDLE.
- program  in  2  top-level phase; block runs only when 2'b11.
- ADC  in  12  unsigned coil-current sample.
- meanCurrent  in  12  averaged current from the mean-current block.
- SWIPT_P_TX, SWIPT_DUTY, SWIPT_FREQ, SWIPT_ASCII, ANC_MAX_HEIGHT, ANC_MIN_HEIGHT, COMMS_TRAJECT, COMMS_QR_CODES, COMMS_FLIGHT_TIME  in  16 each  telemetry words, transmitted in this order.
- RECEIVED_EFF  out  8  last valid efficiency byte.
- RECEIVED_POWER_RX  out  8  last valid received-power byte.
- read  out  1  high while listening for the reply.
- write  out  1  high while transmitting.
- dout  out  1  serial transmit bit, valid while write = 1.
- l_rdy  out  1  one-cycle strobe: l_up_down is valid.
- l_up_down  out  1  0 = increase duty, 1 = decrease duty.
- getMeanCurrent  out  1  request to accumulate mean current.

Behaviour:
- Reset (nrst low, asynchronous): every output is 0; state = IDLE; all counters and shift registers are cleared.
- Abort: whenever swiptAlive = 0 or program != 2'b11, the next clock edge goes to IDLE.
  - read, write, dout, getMeanCurrent and l_rdy go to 0.
  - RECEIVED_EFF and RECEIVED_POWER_RX keep their values.
- IDLE: if program = 2'b11 and swiptAlive = 1, go to MEAS next cycle.
- MEAS:
  - getMeanCurrent = 1 for exactly MEAS_CYCLES cycles.
  - On the following cycle: getMeanCurrent = 0, baseline <= meanCurrent, go to TX.
- TX:
  - write = 1; frame = PREAMBLE (8 bits) then the nine words, MSB first = 152 bits.
  - Each bit is held on dout for exactly BIT_CYCLES cycles.
  - The first bit appears on the cycle write rises.
  - After the last bit, write = 0 and dout = 0 on the next cycle; go to RX_WAIT.
- RX_WAIT:
  - read = 1.
  - Start condition: ADC > baseline + THRESH, compared in 13-bit unsigned arithmetic so there is no wrap-around.
  - On start, wait BIT_CYCLES/2 cycles to reach mid-bit; if the level still qualifies, go to RX_BITS, otherwise stay in RX_WAIT.
  - If no start is found within RX_TIMEOUT cycles: read = 0, no outputs updated, go to MEAS (new round).
- RX_BITS:
  - Sample the ADC comparison every BIT_CYCLES cycles, at mid-bit; 17 bits, MSB first.
  - Bits 16:9 = EFF, bits 8:1 = POWER_RX, bit 0 = up/down.
- DONE (one cycle):
  - read = 0.
  - RECEIVED_EFF and RECEIVED_POWER_RX are updated.
  - l_up_down = bit 0 and l_rdy = 1 for exactly this cycle.
  - Then go to MEAS.
- l_up_down holds its value between strobes.
- l_rdy never pulses in the same cycle as an abort.
- Simultaneous abort and DONE: abort wins and no outputs are updated.
- Telemetry inputs are sampled word-by-word at the first cycle of each word's MSB; changes mid-word do not affect that word.

Optional Feature:
- Macro DATA_LINK_PARITY_EN.
- When defined, the reply carries an 18th bit (even parity over the 17 payload bits).
  - On mismatch, DONE is skipped: no output update, no l_rdy, go to MEAS.
- When undefined, the reply is 17 bits and no check is made.

Test Plan:
- Reset mid-TX (nrst low at bit 40) -> all outputs 0 within the same cycle; after release with program = 11, MEAS restarts with getMeanCurrent high for 1000 cycles.
- program = 11, meanCurrent = 500, all words 16'h9999, BIT_CYCLES = 100:
  - write high for 15200 cycles;
  - dout sequence 1010_0101 then (1001_1001)x18, each level 100 cycles.
- Reply modelled as ADC = 700 for '1' and 500 for '0', bits EFF = 8'h5A, POWER_RX = 8'hC3, up/down = 1 -> RECEIVED_EFF = 5A, RECEIVED_POWER_RX = C3, single-cycle l_rdy with l_up_down = 1.
- ADC held at 560 (below 500 + 64) throughout RX_WAIT -> timeout after 10000 cycles; outputs unchanged; MEAS re-entered.
- swiptAlive dropped during RX_BITS -> read = 0 next cycle; no l_rdy; previous RECEIVED_* values retained.
- With DATA_LINK_PARITY_EN: a reply with a wrong parity bit -> no l_rdy and no update; a correct parity bit -> normal update.
